drum_arbiter: RTL and testbench
===============================

# drum_arbiter

Shares one combinational `drum` approximate signed multiplier among `N_REQ` requesters. Each requester has its own valid/ready operand port. Results return on a single valid/ready response port tagged with the requester index. The block sits between the client interfaces and the `drum` instance and keeps throughput at one product per cycle while the response side is not stalled.

## Interface
- `N_REQ`, 2: number of requesters, 2..8.
- `K`, 5: DRUM truncation width, passed to `drum`.
- `N`, 8: width of operand A (signed).
- `M`, 8: width of operand B (signed).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  N_REQ  per-requester operand valid.
- `req_ready`  out  N_REQ  per-requester accept; at most one bit high.
- `req_a`  in  N_REQ*N  operand A; requester i uses `[i*N +: N]`.
- `req_b`  in  N_REQ*M  operand B; requester i uses `[i*M +: M]`.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  downstream accept.
- `rsp_id`  out  max(1,$clog2(N_REQ))  index of the requester that issued the result.
- `rsp_r`  out  N+M  DRUM product.
- `busy`  out  1  high when any request is in flight: `s1_v | rsp_valid`.

## Operation
- Two-stage pipeline:
  - Stage 1 is the operand register: `s1_a`, `s1_b`, `s1_id`, `s1_v`.
  - Stage 2 is the response register: `rsp_r = drum(s1_a, s1_b)`, `rsp_id`, `rsp_valid`.
- `ld2 = s1_v & (~rsp_valid | rsp_ready)`: stage 2 loads on this. When `rsp_valid & rsp_ready` with `~s1_v`, `rsp_valid` clears.
- `acc = ~s1_v | ld2`: stage 1 can accept on this. When `s1_v` and stage 2 does not load, stage 1 holds.
- Grant selects one requester among those with `req_valid` high.
- `req_ready[i] = grant[i] & acc`. A handshake occurs when `req_valid[i] & req_ready[i]`.
- `req_ready` may depend on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- Once asserted, a requester must hold `req_valid` and its operands stable until the handshake.
- Arbitration state is the round-robin pointer `last`:
  - Priority order is `last+1, last+2, …` modulo N_REQ.
  - `last` updates to the granted index only on a handshake. A grant without a handshake leaves `last` unchanged.
- Arithmetic is exactly that of the existing `drum` module:
  - one's-complement sign handling;
  - exact when both magnitudes are below 2^K;
  - otherwise K-bit truncated mantissas with forced LSB.
  - No rounding or saturation is added.
- Ordering: responses leave in handshake order. At most 2 requests are in flight.

## Timing
- Reset values:
  - `req_ready = 0`, `rsp_valid = 0`, `rsp_r = 0`, `rsp_id = 0`, `busy = 0`.
  - `s1_v = 0`, `last = N_REQ-1`, so requester 0 wins first.
- Latency: a handshake at edge E gives `rsp_valid = 1` after edge E+1 when `rsp_ready` was high or stage 2 was empty.
- Throughput: one handshake per cycle when `rsp_ready` is held high.
- Full stall: `rsp_valid & ~rsp_ready & s1_v` forces all `req_ready = 0`. The next `rsp_ready` edge moves stage 1 to stage 2 and reopens acceptance in the same cycle (`acc = 1`).
- Simultaneous drain and accept in one cycle is legal. Nothing is lost or duplicated.
- Reset asserted mid-operation: in-flight requests are dropped, all outputs return to reset values immediately (asynchronous), and `last` is restored.
- Idle requesters (`req_valid = 0`) never receive `req_ready`.

## Configuration
- `DRUM_ARB_RR_EN` defined: round-robin arbitration as above; `last` is implemented.
- `DRUM_ARB_RR_EN` undefined:
  - fixed priority, lowest index wins;
  - `last` is removed;
  - requester 0 can starve others. This is acceptable for single-client builds.

## Structure
- Package `drum_arb_pkg` holds:
  - default parameter constants;
  - the ID-width function `id_w(n) = (n > 1) ? $clog2(n) : 1`;
  - a packed struct for the stage-1 payload (`a`, `b`, `id`).
- Sub-module `drum_rr_arbiter` (params `N_REQ`) takes `req_valid`, `last`, `adv` and produces one-hot `grant` and `grant_idx`. It contains the `ifdef DRUM_ARB_RR_EN` selection.
- Exactly one `drum` instance is placed between stage 1 and stage 2.

## Test plan
- Reset then single request: req0 `a=3, b=5`, `rsp_ready=1` → `rsp_valid` after 2 edges, `rsp_r=16'd15`, `rsp_id=0`, `busy` high for 2 cycles.
- Approximate path: req1 `a=8'd100, b=8'd100` → `rsp_r=16'h2710`, `rsp_id=1`. Then req0 `a=8'hFF, b=8'd5` → `rsp_r=16'hFFFF`.
- Contention with `DRUM_ARB_RR_EN`: both requesters valid continuously for 6 cycles, `rsp_ready=1` → grants alternate 0,1,0,1,0,1 and `rsp_id` follows that sequence, one per cycle. Without the macro → six grants to requester 0.
- Backpressure: hold `rsp_ready=0` with both requesters valid → exactly 2 handshakes, then all `req_ready=0`. Release → outputs emerge in handshake order with no loss or duplication.
- Reset mid-stream: assert `rst_n=0` while `s1_v` and `rsp_valid` are set → `rsp_valid`, `busy`, `req_ready` drop without a clock edge. After release, requester 0 is granted first.
- Random regression: 10k random operands, valid and ready patterns → every response equals a bench-side DRUM golden model, ids match issue order, and no requester goes ungranted for more than N_REQ handshakes in round-robin mode.

Source files
------------

// File: rtl/drum_arb_pkg.sv
// Shared constants, ID-width helper and stage-1 payload type for drum_arbiter.
// Build option DRUM_ARB_RR_EN selects round-robin over fixed-priority arbitration.
package drum_arb_pkg;

    function automatic int unsigned id_w(input int unsigned n);
        if (n > 1) return $clog2(n);
        return 1;
    endfunction

    localparam int unsigned DRUM_ARB_N_REQ = 2;
    localparam int unsigned DRUM_K         = 5;
    localparam int unsigned DRUM_N         = 8;
    localparam int unsigned DRUM_M         = 8;
    localparam int unsigned DRUM_ARB_ID_W  = id_w(DRUM_ARB_N_REQ);

    // Operand register payload; widths follow the package defaults.
    typedef struct packed {
        logic [DRUM_N-1:0]        a;
        logic [DRUM_M-1:0]        b;
        logic [DRUM_ARB_ID_W-1:0] id;
    } drum_s1_t;

endpackage

// File: rtl/drum.sv
// Combinational DRUM approximate signed multiplier: one's-complement magnitudes,
// operands of K or fewer significant bits pass exactly, wider ones keep K bits with forced LSB.
module drum #(
    parameter int unsigned K = 5,
    parameter int unsigned N = 8,
    parameter int unsigned M = 8
) (
    input  logic [N-1:0]   i_a,
    input  logic [M-1:0]   i_b,
    output logic [N+M-1:0] o_r
);

    localparam int unsigned W = (N > M) ? N : M;

    logic [N-1:0]   w_mag_a;
    logic [M-1:0]   w_mag_b;
    logic [W-1:0]   w_ta;
    logic [W-1:0]   w_tb;
    logic [N+M-1:0] w_p;

    // Keep the K bits below and including the leading one, then force the kept LSB.
    function automatic logic [W-1:0] trunc_mag(input logic [W-1:0] m);
        int unsigned lead;
        int unsigned shift;
        logic [W-1:0] lsb;
        lead = 0;
        for (int i = 0; i < int'(W); i++) begin
            if (m[i]) lead = i;
        end
        if (lead < K) return m;
        shift = lead - K + 1;
        lsb   = W'(1) << shift;
        return (m & ~(lsb - W'(1))) | lsb;
    endfunction

    assign w_mag_a = i_a[N-1] ? ~i_a : i_a;
    assign w_mag_b = i_b[M-1] ? ~i_b : i_b;
    assign w_ta    = trunc_mag(W'(w_mag_a));
    assign w_tb    = trunc_mag(W'(w_mag_b));
    assign w_p     = (N+M)'(w_ta) * (N+M)'(w_tb);
    assign o_r     = (i_a[N-1] ^ i_b[M-1]) ? ~w_p : w_p;

endmodule

// File: rtl/drum_rr_arbiter.sv
// Grant selection for drum_arbiter: round-robin after i_last when DRUM_ARB_RR_EN is defined,
// otherwise fixed priority (lowest index wins). Grants only valid requesters, only when i_adv.
module drum_rr_arbiter
    import drum_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DRUM_ARB_N_REQ
) (
`ifdef DRUM_ARB_RR_EN
    input  logic [id_w(N_REQ)-1:0] i_last,
`endif
    input  logic [N_REQ-1:0]       i_req_valid,
    input  logic                   i_adv,
    output logic [N_REQ-1:0]       o_grant,
    output logic [id_w(N_REQ)-1:0] o_grant_idx
);

    localparam int unsigned IW = id_w(N_REQ);

    logic [IW-1:0] w_idx;

    // Lowest valid index above i_last wins; if none, lowest valid index at or below it.
    always_comb begin
        w_idx = '0;
`ifdef DRUM_ARB_RR_EN
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (i_req_valid[i] && (IW'(i) <= i_last)) w_idx = IW'(i);
        end
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (i_req_valid[i] && (IW'(i) > i_last)) w_idx = IW'(i);
        end
`else
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (i_req_valid[i]) w_idx = IW'(i);
        end
`endif
    end

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            o_grant[i] = i_adv && i_req_valid[i] && (w_idx == IW'(i));
        end
    end

    assign o_grant_idx = w_idx;

endmodule

// File: rtl/drum_arbiter.sv
// Shares one drum multiplier among N_REQ valid/ready requesters through a two-stage pipeline.
// Build option DRUM_ARB_RR_EN enables round-robin arbitration (otherwise fixed priority).
module drum_arbiter
    import drum_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DRUM_ARB_N_REQ,
    parameter int unsigned K     = DRUM_K,
    parameter int unsigned N     = DRUM_N,
    parameter int unsigned M     = DRUM_M
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_REQ-1:0]       i_req_valid,
    output logic [N_REQ-1:0]       o_req_ready,
    input  logic [N_REQ*N-1:0]     i_req_a,
    input  logic [N_REQ*M-1:0]     i_req_b,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [id_w(N_REQ)-1:0] o_rsp_id,
    output logic [N+M-1:0]         o_rsp_r,
    output logic                   o_busy
);

    localparam int unsigned IW = id_w(N_REQ);

    logic           r_en;
    drum_s1_t       r_s1;
    logic           r_s1_v;
    logic           r_rsp_valid;
    logic [N+M-1:0] r_rsp_r;
    logic [IW-1:0]  r_rsp_id;

    logic             w_ld2;
    logic             w_acc;
    logic             w_hs;
    logic [N_REQ-1:0] w_grant;
    logic [IW-1:0]    w_grant_idx;
    logic [N-1:0]     w_sel_a;
    logic [M-1:0]     w_sel_b;
    logic [N+M-1:0]   w_prod;

    // Acceptance stays closed until the first edge after reset so req_ready reads 0 in reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_en <= 1'b0;
        else          r_en <= 1'b1;
    end

    assign w_ld2 = r_s1_v & (~r_rsp_valid | i_rsp_ready);
    assign w_acc = r_en & (~r_s1_v | w_ld2);
    assign w_hs  = |w_grant;

`ifdef DRUM_ARB_RR_EN
    logic [IW-1:0] r_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  r_last <= IW'(N_REQ - 1);
        else if (w_hs) r_last <= w_grant_idx;
    end
`endif

    drum_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
`ifdef DRUM_ARB_RR_EN
        .i_last      (r_last),
`endif
        .i_req_valid (i_req_valid),
        .i_adv       (w_acc),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (w_grant[i]) begin
                w_sel_a = i_req_a[i*N +: N];
                w_sel_b = i_req_b[i*M +: M];
            end
        end
    end

    // Stage 1: operand register; empties when drained without a new handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_v <= 1'b0;
            r_s1   <= '0;
        end else if (w_acc) begin
            r_s1_v <= w_hs;
            if (w_hs) begin
                r_s1.a  <= w_sel_a;
                r_s1.b  <= w_sel_b;
                r_s1.id <= w_grant_idx;
            end
        end
    end

    drum #(
        .K (K),
        .N (N),
        .M (M)
    ) u_drum (
        .i_a (r_s1.a),
        .i_b (r_s1.b),
        .o_r (w_prod)
    );

    // Stage 2: response register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_r     <= '0;
            r_rsp_id    <= '0;
        end else if (w_ld2) begin
            r_rsp_valid <= 1'b1;
            r_rsp_r     <= w_prod;
            r_rsp_id    <= r_s1.id;
        end else if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign o_req_ready = w_grant;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_r     = r_rsp_r;
    assign o_rsp_id    = r_rsp_id;
    assign o_busy      = r_s1_v | r_rsp_valid;

endmodule

// File: tb/tb_drum_arbiter.sv
// Scoreboard bench for drum_arbiter: expected products are queued at each handshake
// from a local DRUM model and compared when responses are accepted.
module tb_drum_arbiter;

    localparam int NR = 2;
    localparam int KW = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [15:0] rsp_r;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int n_rsp = 0;
    logic [15:0] last_r;
    logic        last_id;
    logic [16:0] sb_q[$];
    int          wait_cnt[NR];

    always #5 clk = ~clk;

    drum_arbiter #(
        .N_REQ (2),
        .K     (5),
        .N     (8),
        .M     (8)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_id    (rsp_id),
        .o_rsp_r     (rsp_r),
        .o_busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int approx_mag(input int m);
        int s;
        if (m < (1 << KW)) return m;
        s = 0;
        while ((m >> s) >= (1 << KW)) s++;
        return ((m >> s) | 1) << s;
    endfunction

    function automatic logic [15:0] drum_model(input logic [7:0] a, input logic [7:0] b);
        int sa, sb, ma, mb, p;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ma = (sa < 0) ? -sa - 1 : sa;
        mb = (sb < 0) ? -sb - 1 : sb;
        p  = approx_mag(ma) * approx_mag(mb);
        if ((sa < 0) != (sb < 0)) p = -p - 1;
        return 16'(p);
    endfunction

    function automatic logic [7:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 8'h80;
            1:       return 8'h7F;
            2:       return 8'hFF;
            3:       return 8'($urandom_range(0, 31));
            default: return 8'($urandom);
        endcase
    endfunction

    // Response pop, handshake push and per-cycle ready rules.
    always @(negedge clk) begin
        logic [16:0] e;
        logic [1:0]  hs;
        if (rst_n) begin
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 32'(sb_q.size()), 1);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_r", 32'(rsp_r), 32'(e[15:0]));
                    check("rsp_id", 32'(rsp_id), 32'(e[16]));
                end
                last_r  = rsp_r;
                last_id = rsp_id[0];
                n_rsp++;
            end
            check("ready_idle", 32'(req_ready & ~req_valid), 0);
            check("ready_onehot", 32'($countones(req_ready) <= 1), 1);
            hs = req_valid & req_ready;
            for (int i = 0; i < NR; i++) begin
                if (hs[i]) sb_q.push_back({1'(i), drum_model(req_a[i*8 +: 8], req_b[i*8 +: 8])});
            end
`ifdef DRUM_ARB_RR_EN
            for (int i = 0; i < NR; i++) begin
                if (hs[i]) begin
                    check("rr_fair", 32'(wait_cnt[i] < NR), 1);
                    wait_cnt[i] = 0;
                end else if (!req_valid[i]) begin
                    wait_cnt[i] = 0;
                end else if (hs != 2'b00) begin
                    wait_cnt[i]++;
                end
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        sb_q.delete();
        for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_sb();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!busy) return;
        end
        check("drain_timeout", 32'(busy), 0);
    endtask

    task automatic send(input int id, input logic [7:0] a, input logic [7:0] b);
        tick();
        req_valid[id]     = 1'b1;
        req_a[id*8 +: 8]  = a;
        req_b[id*8 +: 8]  = b;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                tick();
                req_valid[id] = 1'b0;
                return;
            end
        end
        check("send_timeout", 32'(req_ready[id]), 1);
        req_valid[id] = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int cnt;
        int hs_total;
        logic [1:0] hs;

        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        clear_sb();

        // Reset values
        #12;
        check("rst_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_r", 32'(rsp_r), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_busy", 32'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // Single request: 3*5, latency and busy window
        req_valid = 2'b01;
        req_a     = 16'h0003;
        req_b     = 16'h0005;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t1_ready", 32'(req_ready), 32'h1);
        check("t1_busy_pre", 32'(busy), 0);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        check("t1_valid_e1", 32'(rsp_valid), 0);
        check("t1_busy_e1", 32'(busy), 1);
        tick();
        @(negedge clk);
        check("t1_valid_e2", 32'(rsp_valid), 1);
        check("t1_r", 32'(rsp_r), 32'd15);
        check("t1_id", 32'(rsp_id), 0);
        check("t1_busy_e2", 32'(busy), 1);
        tick();
        @(negedge clk);
        check("t1_valid_e3", 32'(rsp_valid), 0);
        check("t1_busy_e3", 32'(busy), 0);

        // Approximate path and negative operand
        send(1, 8'd100, 8'd100);
        drain();
        check("t2_r_100x100", 32'(last_r), 32'h2710);
        check("t2_id_100x100", 32'(last_id), 1);
        send(0, 8'hFF, 8'd5);
        drain();
        check("t2_r_m1x5", 32'(last_r), 32'hFFFF);
        check("t2_id_m1x5", 32'(last_id), 0);

        // Contention: six back-to-back grants
        do_reset();
        n0        = n_rsp;
        req_a     = {8'd7, 8'd6};
        req_b     = {8'd9, 8'd40};
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
`ifdef DRUM_ARB_RR_EN
            check("t3_grant", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
`else
            check("t3_grant", 32'(req_ready), 32'h1);
`endif
            tick();
        end
        req_valid = 2'b00;
        drain();
        check("t3_rsp_count", 32'(n_rsp - n0), 6);

        // Backpressure: two handshakes then full stall
        tick();
        req_a     = {8'hC3, 8'd77};
        req_b     = {8'd50, 8'h9A};
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        cnt       = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            cnt += $countones(req_valid & req_ready);
            tick();
        end
        check("t4_hs_count", 32'(cnt), 2);
        check("t4_stall_ready", 32'(req_ready), 0);
        req_valid = 2'b00;
        n0        = n_rsp;
        drain();
        check("t4_rsp_count", 32'(n_rsp - n0), 2);

        // Reset mid-stream after requester 0 was last served
        tick();
        req_a     = {8'd11, 8'd90};
        req_b     = {8'd13, 8'hF0};
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        tick();
        tick();
        tick();
        check("t5_busy_full", 32'(busy), 1);
        check("t5_rsp_full", 32'(rsp_valid), 1);
        req_valid = 2'b11;
        #2;
        check("t5_stall_ready", 32'(req_ready), 0);
        rst_n = 1'b0;
        clear_sb();
        #1;
        check("t5_rst_rsp_valid", 32'(rsp_valid), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_ready", 32'(req_ready), 0);
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        check("t5_first_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        drain();

        // Random regression
        hs_total = 0;
        for (int c = 0; c < 60000 && hs_total < 10000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 2) != 0)) begin
                    req_valid[i]     = 1'b1;
                    req_a[i*8 +: 8]  = rand_op();
                    req_b[i*8 +: 8]  = rand_op();
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            hs = req_valid & req_ready;
            hs_total += $countones(hs);
            tick();
            req_valid = req_valid & ~hs;
        end
        check("t6_hs_total", 32'(hs_total >= 10000), 1);
        req_valid = 2'b00;
        drain();
        check("t6_sb_empty", 32'(sb_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
